product_accumulator: RTL and testbench
======================================

# product_accumulator

- Downstream stage of the pipelined 4×4 multiplier.
- Consumes one 8-bit product per valid cycle and sums COUNT consecutive products into an ACC_W-bit total.
- Presents each completed total on a registered valid/ready output, so slow consumers (UART, display mux) can read block sums while the multiplier keeps streaming.
- The next accumulation proceeds in parallel with a held output.

## Interface
Parameters:
- PROD_W, 8, width of incoming product
- ACC_W, 16, width of accumulator and output sum
- COUNT, 4, products per block (≥2; counter width = clog2(COUNT))

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_product valid this cycle (no backpressure toward multiplier)
- in_product  in  PROD_W  unsigned product from multiplier
- clear  in  1  discard partial block, restart count
- out_valid  out  1  out_sum holds an unconsumed block total
- out_ready  in  1  consumer accepts out_sum this cycle
- out_sum  out  ACC_W  block total
- out_sat  out  1  total was clipped (SAT_EN only; else constant 0)
- overrun  out  1  sticky: a completed block was dropped

## Operation
- Internal state: acc[ACC_W], cnt (0..COUNT-1), output register {out_sum, out_sat}, out_valid, overrun, sat_pend.
- Reset (rst=1 at edge): acc=0, cnt=0, out_sum=0, out_sat=0, out_valid=0, overrun=0, sat_pend=0.
- Priority per cycle: rst > clear > in_valid.
- clear=1: acc=0, cnt=0, sat_pend=0; in_product that cycle discarded; output register, out_valid and overrun untouched.
- in_valid=1, cnt<COUNT-1: acc=acc+in_product (zero-extended), cnt+=1.
- in_valid=1, cnt==COUNT-1 (block completes): total=acc+in_product; acc=0, cnt=0, sat_pend=0.
  - If the output slot is free (out_valid=0, or out_valid=1 and out_ready=1 this cycle): out_sum=total, out_sat=sat_pend|clip, out_valid=1.
  - Otherwise: total dropped, old output held unchanged, overrun=1.
- Handshake: transfer when out_valid & out_ready at an edge. out_valid falls the next cycle unless a block completes in the same cycle, in which case out_valid stays 1 with the new total. This is not an overrun.
- out_sum/out_sat stable while out_valid=1 and out_ready=0.
- overrun clears only on rst.
- Arithmetic is unsigned. Overflow behaviour is set by SAT_EN (see Configuration).

## Timing
- Latency: out_valid rises on the edge that samples the COUNT-th in_valid; out_sum is visible the same cycle out_valid rises. One cycle after the final product is presented.
- Throughput: one product per clock, indefinitely, with out_ready held 1.
- in_valid gaps are allowed; cnt holds during gaps.
- Reset mid-block or with out_valid=1: all state lost, no output produced.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro PRODUCT_ACCUMULATOR_SAT_EN.
- Defined:
  - Every addition is clamped at 2^ACC_W−1.
  - Any clamp within a block sets sat_pend, reported on out_sat with that block's total.
  - acc stays at max for the rest of the block.
- Undefined:
  - Additions wrap modulo 2^ACC_W.
  - sat_pend logic is absent and out_sat is tied 0.

## Test plan
- Basic block: COUNT=4, out_ready=1, products 15,30,45,225 on consecutive cycles -> one cycle after 225, out_valid=1 and out_sum=315 for one cycle; out_sat=0, overrun=0.
- Backpressure/overrun: out_ready=0, stream 8 products of 10 -> first out_sum=40 held with out_valid=1. Second block is dropped and overrun=1. Raise out_ready -> 40 transfers, then out_valid=0.
- Simultaneous: with out_valid=1, assert out_ready on the same cycle the next block completes (4×2) -> out_valid stays 1, out_sum=8, overrun stays 0.
- Clear: products 100,100, then clear with in_valid=1 and product 50, then 1,2,3,4 -> out_sum=10. The 100s and the 50 are excluded.
- Saturation (ACC_W=10, COUNT=8, 8×225):
  - SAT_EN defined -> out_sum=1023, out_sat=1.
  - SAT_EN undefined -> out_sum=1800 mod 1024=776, out_sat=0.
- Reset mid-block: 2 products, rst for one cycle, then 4 products of 3 -> out_sum=12; all outputs 0 while rst is high.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive products into a block total
// and presents it on a registered valid/ready slot. Optional clamping via PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_product,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              overrun
);

    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sat_q, sat_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             pend_q, pend_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_res;
    logic             clip;
    logic             last;
    logic             slot_free;

    assign prod_ext  = ACC_W'(in_product);
    assign last      = (cnt_q == CNT_LAST);
    assign slot_free = !vld_q || out_ready;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    logic [ACC_W:0] sum_w;

    // Widened add; the carry out marks a clamp to all-ones
    always_comb begin
        sum_w   = {1'b0, acc_q} + {1'b0, prod_ext};
        clip    = sum_w[ACC_W];
        add_res = clip ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    end
`else
    // Plain modulo-2^ACC_W add; no clamp ever reported
    always_comb begin
        add_res = acc_q + prod_ext;
        clip    = 1'b0;
    end
`endif

    // Next-state: clear beats in_valid, transfer frees the slot
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        sat_d  = sat_q;
        vld_d  = vld_q && !out_ready;
        ovr_d  = ovr_q;
        pend_d = pend_q;
        if (clear) begin
            acc_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (in_valid) begin
            if (last) begin
                acc_d  = '0;
                cnt_d  = '0;
                pend_d = 1'b0;
                if (slot_free) begin
                    sum_d = add_res;
                    sat_d = pend_q || clip;
                    vld_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                acc_d  = add_res;
                cnt_d  = cnt_q + CNT_W'(1);
                pend_d = pend_q || clip;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            sat_q  <= 1'b0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            sat_q  <= sat_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
            pend_q <= pend_d;
        end
    end

    assign out_valid = vld_q;
    assign out_sum   = sum_q;
    assign overrun   = ovr_q;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    assign out_sat   = sat_q;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: table of per-cycle vectors
// plus hand-written streaming and saturation sequences.
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Default-parameter DUT
    logic        rst = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_product = '0;
    logic        out_valid, out_sat, overrun;
    logic [15:0] out_sum;

    product_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_product(in_product),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_sat(out_sat), .overrun(overrun)
    );

    // Narrow DUT for the overflow case
    logic        rst2 = 1'b0, clear2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [7:0]  in_product2 = '0;
    logic        out_valid2, out_sat2, overrun2;
    logic [9:0]  out_sum2;

    product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(8)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_product(in_product2),
        .clear(clear2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_sat(out_sat2), .overrun(overrun2)
    );

    typedef struct {
        logic        r;
        logic        c;
        logic        v;
        logic [7:0]  p;
        logic        rdy;
        logic        ev;
        logic [15:0] es;
        logic        esat;
        logic        eov;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic v, int p, logic rdy,
                                logic ev, int es, logic eov);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.p = 8'(p); t.rdy = rdy;
        t.ev = ev; t.es = 16'(es); t.esat = 1'b0; t.eov = eov;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, exp);
    endtask

    initial begin
        // reset
        vecs.push_back(mk(1,0,0,0,1, 0,0,0));
        // basic block 15,30,45,225
        vecs.push_back(mk(0,0,1,15,1, 0,0,0));
        vecs.push_back(mk(0,0,1,30,1, 0,0,0));
        vecs.push_back(mk(0,0,1,45,1, 0,0,0));
        vecs.push_back(mk(0,0,1,225,1, 1,315,0));
        vecs.push_back(mk(0,0,0,0,1, 0,315,0));
        // backpressure: 8x10 with ready low
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,10,0, 0,315,0));
        vecs.push_back(mk(0,0,1,10,0, 1,40,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,10,0, 1,40,0));
        vecs.push_back(mk(0,0,1,10,0, 1,40,1));
        vecs.push_back(mk(0,0,0,0,1, 0,40,1));
        vecs.push_back(mk(0,0,0,0,0, 0,40,1));
        // simultaneous transfer and completion
        vecs.push_back(mk(1,0,0,0,0, 0,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 1,4,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,2,0, 1,4,0));
        vecs.push_back(mk(0,0,1,2,1, 1,8,0));
        vecs.push_back(mk(0,0,0,0,1, 0,8,0));
        // clear discards partial block and its own product
        vecs.push_back(mk(0,0,1,100,1, 0,8,0));
        vecs.push_back(mk(0,0,1,100,1, 0,8,0));
        vecs.push_back(mk(0,1,1,50,1, 0,8,0));
        vecs.push_back(mk(0,0,1,1,1, 0,8,0));
        vecs.push_back(mk(0,0,1,2,1, 0,8,0));
        vecs.push_back(mk(0,0,1,3,1, 0,8,0));
        vecs.push_back(mk(0,0,1,4,1, 1,10,0));
        vecs.push_back(mk(0,0,0,0,1, 0,10,0));
        // gaps hold the count
        vecs.push_back(mk(0,0,1,5,1, 0,10,0));
        vecs.push_back(mk(0,0,0,9,1, 0,10,0));
        vecs.push_back(mk(0,0,1,5,1, 0,10,0));
        vecs.push_back(mk(0,0,0,9,1, 0,10,0));
        vecs.push_back(mk(0,0,1,5,1, 0,10,0));
        vecs.push_back(mk(0,0,1,5,0, 1,20,0));
        // reset mid-block while a total is pending
        vecs.push_back(mk(0,0,1,7,0, 1,20,0));
        vecs.push_back(mk(0,0,1,7,0, 1,20,0));
        vecs.push_back(mk(1,0,1,9,0, 0,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,3,0, 0,0,0));
        vecs.push_back(mk(0,0,1,3,0, 1,12,0));
        // clear leaves a held output alone
        vecs.push_back(mk(0,1,0,0,0, 1,12,0));

        foreach (vecs[i]) begin
            rst        = vecs[i].r;
            clear      = vecs[i].c;
            in_valid   = vecs[i].v;
            in_product = vecs[i].p;
            out_ready  = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].ev));
            check("out_sum", i, 32'(out_sum), 32'(vecs[i].es));
            check("out_sat", i, 32'(out_sat), 32'(vecs[i].esat));
            check("overrun", i, 32'(overrun), 32'(vecs[i].eov));
        end

        // continuous stream 1..12 with ready held high
        rst = 1'b0; clear = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_valid   = 1'b1;
            in_product = 8'(k);
            @(posedge clk);
            #1;
            check("stream_valid", k, 32'(out_valid), 32'(k % 4 == 0));
            if (k % 4 == 0)
                check("stream_sum", k, 32'(out_sum), 32'(16 * (k / 4) - 6));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_drain", 0, 32'(out_valid), 32'd0);
        check("stream_ovr", 0, 32'(overrun), 32'd0);

        // overflow on the narrow DUT: 8 x 225
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        check("sat_rst_valid", 0, 32'(out_valid2), 32'd0);
        rst2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid2   = 1'b1;
            in_product2 = 8'd225;
            @(posedge clk);
            #1;
            check("sat_valid", k, 32'(out_valid2), 32'(k == 7));
        end
        in_valid2 = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        check("sat_sum", 0, 32'(out_sum2), 32'd1023);
        check("sat_flag", 0, 32'(out_sat2), 32'd1);
`else
        check("sat_sum", 0, 32'(out_sum2), 32'd776);
        check("sat_flag", 0, 32'(out_sat2), 32'd0);
`endif
        check("sat_ovr", 0, 32'(overrun2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
